// File: rtl/dec_xfm_coeff_reorder.sv
// Coefficient reorder: maps entropy-order coefficients to raster order per chroma format and component; DEC_XFM_NZ_CNT_EN adds a nonzero count.
// Latency: 1 cycle from accept to out_valid through a DEPTH-entry output FIFO.
// Backpressure: in_ready = FIFO not full (state only, no path from out_ready); out_* hold while out_ready is low.
module dec_xfm_coeff_reorder #(
    parameter int COEF_W    = 9,
    parameter int NUM_COEFF = 16,
    parameter int NUM_COMP  = 3,
    parameter int DEPTH     = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic [1:0]                  chroma_fmt,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_mode_xfm,
    input  logic [NUM_COEFF*COEF_W-1:0] in_coeff,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_COEFF*COEF_W-1:0] out_coeff,
    output logic [1:0]                  out_comp,
    output logic                        out_last,
    output logic                        out_mode_xfm,
    output logic [4:0]                  out_nz_cnt
);
    localparam int DW    = NUM_COEFF * COEF_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [1:0]       COMP_LAST = 2'(NUM_COMP - 1);
    // Source index per raster position, 4 bits per entry, entry 0 in the low nibble.
    localparam logic [63:0] MAP444 = {4'd15, 4'd14, 4'd13, 4'd12, 4'd8, 4'd7, 4'd6, 4'd3,
                                      4'd11, 4'd10, 4'd9, 4'd5, 4'd4, 4'd2, 4'd1, 4'd0};
    localparam logic [31:0] MAP422 = {4'd7, 4'd6, 4'd3, 4'd2, 4'd5, 4'd4, 4'd1, 4'd0};

    logic [CNT_W-1:0] fifo_cnt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [1:0]       comp_cnt;
    logic [1:0]       fmt_q;
    logic [DW-1:0]    coeff_mem [DEPTH];
    logic [1:0]       comp_mem  [DEPTH];
    logic             mode_mem  [DEPTH];
    logic [DW-1:0]    mapped;
    logic             push;
    logic             pop;

    assign in_ready  = rst_n && (fifo_cnt < DEPTH_C);
    assign out_valid = (fifo_cnt != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    // Comp 0 is always 444-mapped, so only chroma components need the latched format.
    always_comb begin
        mapped = '0;
        for (int i = 0; i < NUM_COEFF; i++) begin
            if (!in_mode_xfm) begin
                mapped[i*COEF_W +: COEF_W] = in_coeff[i*COEF_W +: COEF_W];
            end else if (comp_cnt == 2'd0 || fmt_q == 2'd0 || fmt_q == 2'd3) begin
                mapped[i*COEF_W +: COEF_W] = in_coeff[int'(MAP444[i*4 +: 4])*COEF_W +: COEF_W];
            end else if (fmt_q == 2'd1) begin
                if (i < 8)
                    mapped[i*COEF_W +: COEF_W] = in_coeff[int'(MAP422[i*4 +: 4])*COEF_W +: COEF_W];
            end else begin
                if (i < 4)
                    mapped[i*COEF_W +: COEF_W] = in_coeff[i*COEF_W +: COEF_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            comp_cnt <= 2'd0;
            if (!rst_n)
                fmt_q <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr   <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
                comp_cnt <= (comp_cnt == COMP_LAST) ? 2'd0 : comp_cnt + 2'd1;
                if (comp_cnt == 2'd0)
                    fmt_q <= chroma_fmt;
            end
            if (pop)
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)
                fifo_cnt <= fifo_cnt + 1'b1;
            else if (pop && !push)
                fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            coeff_mem[wr_ptr] <= mapped;
            comp_mem[wr_ptr]  <= comp_cnt;
            mode_mem[wr_ptr]  <= in_mode_xfm;
        end
    end

    assign out_coeff    = out_valid ? coeff_mem[rd_ptr] : '0;
    assign out_comp     = out_valid ? comp_mem[rd_ptr] : 2'd0;
    assign out_mode_xfm = out_valid && mode_mem[rd_ptr];
    assign out_last     = out_valid && (comp_mem[rd_ptr] == COMP_LAST);

`ifdef DEC_XFM_NZ_CNT_EN
    logic [4:0] nz_new;
    logic [4:0] nz_mem [DEPTH];

    always_comb begin
        nz_new = 5'd0;
        for (int i = 0; i < NUM_COEFF; i++)
            if (mapped[i*COEF_W +: COEF_W] != '0)
                nz_new = nz_new + 5'd1;
    end

    always_ff @(posedge clk) begin
        if (push)
            nz_mem[wr_ptr] <= nz_new;
    end

    assign out_nz_cnt = out_valid ? nz_mem[rd_ptr] : 5'd0;
`else
    assign out_nz_cnt = 5'd0;
`endif
endmodule

// File: tb/tb_dec_xfm_coeff_reorder.sv
// Bench for dec_xfm_coeff_reorder: table-driven vectors plus backpressure and flush sequences, scoreboard queue.
module tb_dec_xfm_coeff_reorder;
    localparam int CW = 9;
    localparam int NC = 16;
    localparam int W  = CW * NC;
`ifdef DEC_XFM_NZ_CNT_EN
    localparam bit NZ_EN = 1'b1;
`else
    localparam bit NZ_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   chroma_fmt = 2'd0;
    logic         in_valid = 1'b0;
    logic         in_mode_xfm = 1'b0;
    logic [W-1:0] in_coeff = '0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_coeff;
    logic [1:0]   out_comp;
    logic         out_last;
    logic         out_mode_xfm;
    logic [4:0]   out_nz_cnt;

    dec_xfm_coeff_reorder dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .chroma_fmt(chroma_fmt),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode_xfm(in_mode_xfm),
        .in_coeff(in_coeff), .out_valid(out_valid), .out_ready(out_ready),
        .out_coeff(out_coeff), .out_comp(out_comp), .out_last(out_last),
        .out_mode_xfm(out_mode_xfm), .out_nz_cnt(out_nz_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] coeff;
        logic [1:0]   comp;
        logic         last;
        logic         mode;
        logic [4:0]   nz;
    } exp_t;

    typedef struct {
        logic [1:0]   fmt;
        logic         mode;
        logic [W-1:0] din;
        logic [W-1:0] dexp;
        logic [1:0]   comp;
    } vec_t;

    exp_t       q[$];
    int         checks = 0;
    int         failures = 0;
    int         m_comp = 0;
    logic [1:0] m_fmtq = 2'd0;

    function automatic logic [W-1:0] pk(input int a[16]);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < NC; i++) r[i*CW +: CW] = CW'(a[i]);
        return r;
    endfunction

    function automatic logic [4:0] nz_of(input logic [W-1:0] c);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < NC; i++) if (c[i*CW +: CW] != '0) n = n + 5'd1;
        return NZ_EN ? n : 5'd0;
    endfunction

    function automatic logic [W-1:0] ref_map(input logic [W-1:0] d, input logic m,
                                              input int comp, input logic [1:0] f);
        int m444[16] = '{0, 1, 2, 4, 5, 9, 10, 11, 3, 6, 7, 8, 12, 13, 14, 15};
        int m422[8]  = '{0, 1, 4, 5, 2, 3, 6, 7};
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < NC; i++) begin
            if (!m) r[i*CW +: CW] = d[i*CW +: CW];
            else if (comp == 0 || f == 2'd0 || f == 2'd3) r[i*CW +: CW] = d[m444[i]*CW +: CW];
            else if (f == 2'd1) begin
                if (i < 8) r[i*CW +: CW] = d[m422[i]*CW +: CW];
            end else if (i < 4) r[i*CW +: CW] = d[i*CW +: CW];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // One cycle: drive at negedge, check/score just after, edge follows.
    task automatic step(input logic v, input logic [1:0] f, input logic m, input logic [W-1:0] d,
                        input logic fl, input logic ordy, input logic tbl, input exp_t te);
        exp_t       e;
        logic [1:0] fu;
        @(negedge clk);
        in_valid = v; chroma_fmt = f; in_mode_xfm = m; in_coeff = d; flush = fl; out_ready = ordy;
        #1;
        chk("out_valid_occupancy", W'(out_valid), W'(q.size() != 0));
        chk("in_ready_occupancy", W'(in_ready), W'(q.size() < 2));
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_beat actual=%h required=none", out_coeff);
            end else begin
                e = q.pop_front();
                chk("out_coeff", out_coeff, e.coeff);
                chk("out_comp_last_mode_nz", W'({out_comp, out_last, out_mode_xfm, out_nz_cnt}),
                    W'({e.comp, e.last, e.mode, e.nz}));
            end
        end
        if (fl) begin
            q.delete();
            m_comp = 0;
        end else if (in_valid && in_ready) begin
            fu = (m_comp == 0) ? f : m_fmtq;
            if (m_comp == 0) m_fmtq = f;
            if (tbl) e = te;
            else begin
                e.coeff = ref_map(d, m, m_comp, fu);
                e.comp  = 2'(m_comp);
                e.mode  = m;
            end
            e.last = (e.comp == 2'd2);
            e.nz   = nz_of(e.coeff);
            q.push_back(e);
            m_comp = (m_comp == 2) ? 0 : m_comp + 1;
        end
    endtask

    task automatic beat(input logic v, input logic [1:0] f, input logic m, input logic [W-1:0] d,
                        input logic fl, input logic ordy);
        exp_t none;
        none = '{default: '0};
        step(v, f, m, d, fl, ordy, 1'b0, none);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tv[18];
        exp_t         te;
        int           a[16];
        logic [W-1:0] seq, p1, byp, neg, e444s, e444p, e422p, e420p, eneg;
        int           n;

        for (int k = 0; k < 16; k++) a[k] = k;                    seq = pk(a);
        for (int k = 0; k < 16; k++) a[k] = k + 1;                p1 = pk(a);
        for (int k = 0; k < 16; k++) a[k] = k * 3 - 20;           byp = pk(a);
        for (int k = 0; k < 16; k++) a[k] = (k % 2 == 1) ? -1 : 0; neg = pk(a);
        a = '{0, 1, 2, 4, 5, 9, 10, 11, 3, 6, 7, 8, 12, 13, 14, 15};  e444s = pk(a);
        a = '{1, 2, 3, 5, 6, 10, 11, 12, 4, 7, 8, 9, 13, 14, 15, 16}; e444p = pk(a);
        a = '{1, 2, 5, 6, 3, 4, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0};        e422p = pk(a);
        a = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};        e420p = pk(a);
        a = '{0, -1, 0, 0, -1, -1, 0, -1, -1, 0, -1, 0, 0, -1, 0, -1}; eneg = pk(a);

        tv[0]  = '{2'd0, 1'b1, seq, e444s, 2'd0};
        tv[1]  = '{2'd0, 1'b1, seq, e444s, 2'd1};
        tv[2]  = '{2'd0, 1'b1, seq, e444s, 2'd2};
        tv[3]  = '{2'd1, 1'b1, p1, e444p, 2'd0};
        tv[4]  = '{2'd1, 1'b1, p1, e422p, 2'd1};
        tv[5]  = '{2'd1, 1'b1, p1, e422p, 2'd2};
        tv[6]  = '{2'd1, 1'b1, p1, e444p, 2'd0};
        tv[7]  = '{2'd2, 1'b1, p1, e422p, 2'd1};   // fmt changes mid-block: latched 422 holds
        tv[8]  = '{2'd2, 1'b1, p1, e422p, 2'd2};
        tv[9]  = '{2'd2, 1'b1, p1, e444p, 2'd0};
        tv[10] = '{2'd2, 1'b1, p1, e420p, 2'd1};
        tv[11] = '{2'd3, 1'b1, p1, e420p, 2'd2};
        tv[12] = '{2'd2, 1'b0, byp, byp, 2'd0};
        tv[13] = '{2'd2, 1'b0, byp, byp, 2'd1};
        tv[14] = '{2'd2, 1'b0, byp, byp, 2'd2};
        tv[15] = '{2'd0, 1'b1, neg, eneg, 2'd0};
        tv[16] = '{2'd3, 1'b1, neg, eneg, 2'd1};
        tv[17] = '{2'd3, 1'b1, neg, eneg, 2'd2};

        repeat (3) @(negedge clk);
        #1;
        chk("reset_in_ready", W'(in_ready), W'(0));
        chk("reset_out_valid", W'(out_valid), W'(0));
        chk("reset_out_coeff", out_coeff, '0);
        chk("reset_meta", W'({out_comp, out_last, out_mode_xfm, out_nz_cnt}), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_reset", W'(in_ready), W'(1));

        for (int i = 0; i < 18; i++) begin
            te.coeff = tv[i].dexp;
            te.comp  = tv[i].comp;
            te.mode  = tv[i].mode;
            te.last  = 1'b0;
            te.nz    = 5'd0;
            step(1'b1, tv[i].fmt, tv[i].mode, tv[i].din, 1'b0, 1'b1, 1'b1, te);
        end
        beat(1'b0, 2'd0, 1'b0, '0, 1'b0, 1'b1);
        beat(1'b0, 2'd0, 1'b0, '0, 1'b0, 1'b1);

        // Backpressure: fill both slots, hold, release one cycle.
        beat(1'b1, 2'd0, 1'b1, p1, 1'b0, 1'b0);
        beat(1'b1, 2'd0, 1'b1, seq, 1'b0, 1'b0);
        beat(1'b1, 2'd0, 1'b1, seq, 1'b0, 1'b0);
        chk("full_in_ready", W'(in_ready), W'(0));
        chk("stall_head_hold", out_coeff, e444p);
        beat(1'b1, 2'd0, 1'b1, seq, 1'b0, 1'b0);
        chk("stall_head_hold2", out_coeff, e444p);
        beat(1'b1, 2'd0, 1'b1, seq, 1'b0, 1'b1);
        beat(1'b1, 2'd0, 1'b1, p1, 1'b0, 1'b0);
        chk("in_ready_after_pop", W'(in_ready), W'(1));
        n = 0;
        while (q.size() != 0 && n < 10) begin
            beat(1'b0, 2'd0, 1'b0, '0, 1'b0, 1'b1);
            n++;
        end
        chk("drain_complete", W'(q.size()), W'(0));

        // Flush during comp1 drops the beat and restarts at comp 0.
        beat(1'b1, 2'd1, 1'b1, p1, 1'b0, 1'b1);
        beat(1'b1, 2'd1, 1'b1, p1, 1'b1, 1'b1);
        beat(1'b0, 2'd0, 1'b0, '0, 1'b0, 1'b1);
        chk("flush_out_valid", W'(out_valid), W'(0));
        beat(1'b1, 2'd2, 1'b1, p1, 1'b0, 1'b1);
        beat(1'b0, 2'd0, 1'b0, '0, 1'b0, 1'b1);
        chk("post_flush_comp", W'(out_comp), W'(0));
        chk("post_flush_coeff", out_coeff, e444p);
        beat(1'b0, 2'd0, 1'b0, '0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
